// File: rtl/mult_seq_11x11.sv
// mult_seq_11x11 -- sequential shift-and-add unsigned multiplier.
//
// One operand pair is accepted from IDLE when start is high. The multiplier
// is consumed one bit per RUN cycle (WIDTH cycles), the product is written to
// prod on the RUN->DONE transition, and done pulses for one cycle in DONE.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous reset, active low
//   start - request, sampled only in IDLE
//   a     - multiplicand (unsigned, WIDTH bits)
//   b     - multiplier   (unsigned, WIDTH bits)
//   busy  - high while in RUN
//   done  - one-cycle completion pulse (DONE state)
//   prod  - registered product of the last completed operation (2*WIDTH bits)
//
// Build option:
//   MULT_EARLY_EXIT_EN - when defined, RUN ends as soon as the remaining
//   multiplier bits are all zero; results are identical, only latency shrinks.

module mult_seq_11x11 #(
  parameter int unsigned WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

  state_t               state;
  state_t               state_nxt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [3:0]           cnt;
  logic [2*WIDTH-1:0]   sum_nxt;
  logic                 last_step;

  // Partial sum including the current multiplier bit; on the final RUN edge
  // this is the complete product.
  always_comb begin
    sum_nxt = acc + (mplier[0] ? mcand : '0);
  end

`ifdef MULT_EARLY_EXIT_EN
  // Stop once no set multiplier bits remain after this step's shift.
  always_comb begin
    last_step = (cnt == CNT_LAST) || ((mplier >> 1) == '0);
  end
`else
  always_comb begin
    last_step = (cnt == CNT_LAST);
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: operand shift registers, partial sum, step counter, result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      prod   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= sum_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (last_step) begin
            prod <= sum_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mult_seq_11x11.md
MULT_SEQ_11X11 -- requirements
Module: mult_seq_11x11

Interface
REQ-001 Parameter: WIDTH, 11, operand width; product width is 2*WIDTH (22), matching the accumulator input.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 Port: start  input  1  request; sampled at a rising clk edge only while in IDLE.
REQ-005 Port: a  input  WIDTH  multiplicand, unsigned, captured on accepted start.
REQ-006 Port: b  input  WIDTH  multiplier, unsigned, captured on accepted start.
REQ-007 Port: busy  output  1  high while in RUN.
REQ-008 Port: done  output  1  one-cycle pulse, high only in DONE.
REQ-009 Port: prod  output  2*WIDTH  registered product of the last completed operation.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE; busy=(state==RUN); done=(state==DONE).
REQ-011 IDLE, start=1 at edge: capture a into a shift-left register (2*WIDTH wide), b into a shift-right register, clear the partial sum, clear the 4-bit step counter, go RUN.
REQ-012 IDLE, start=0: remain IDLE; a and b ignored.
REQ-013 Each RUN edge: partial sum += shifted multiplicand when multiplier LSB=1; multiplicand <<1; multiplier >>1; counter +1.
REQ-014 RUN edge with counter==WIDTH-1: write the final partial sum into prod, go DONE; accept-to-done latency is exactly WIDTH+1 edges (RUN lasts WIDTH cycles).
REQ-015 DONE: go IDLE on the next edge unconditionally; start in DONE is ignored (minimum issue interval WIDTH+2 cycles).
REQ-016 start during RUN or DONE SHALL be ignored and SHALL NOT disturb the operation in flight or the captured operands.
REQ-017 prod SHALL update only on the RUN->DONE transition and SHALL hold its value in all other cycles, including through later starts until the next completion.
REQ-018 Arithmetic SHALL be unsigned and exact; the maximum (2^WIDTH-1)^2 fits in 2*WIDTH bits, with no overflow or truncation.
REQ-019 Operand zero (a=0 or b=0) SHALL follow the normal timing and produce prod=0.

Reset
REQ-020 rst=0 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, prod=0, and clear the counter, operand and partial-sum registers.
REQ-021 Reset asserted mid-RUN SHALL abandon the operation; prod SHALL read 0, not a partial result.
REQ-022 After rst deasserts, the first accepted start SHALL occur no earlier than the first rising edge with rst=1.

Configuration
REQ-023 Macro MULT_EARLY_EXIT_EN, when defined: a RUN edge whose shifted multiplier result is zero SHALL write prod and go DONE on that same edge, so latency is (index of the highest set bit of b)+2 edges (b=0 or b=1: 2 edges).
REQ-024 With MULT_EARLY_EXIT_EN undefined: fixed latency per REQ-014, and no early-exit logic is synthesized.
REQ-025 Results SHALL be identical with and without the macro; only timing differs.

Verification
REQ-026 Reset with no start: rst=0 then 1 -> prod=0, busy=0, done=0; 20 idle cycles keep all outputs at 0.
REQ-027 a=134, b=132, start pulse -> busy for 11 cycles, done pulse on the 12th edge, prod=17688; a=200, b=150 next -> prod=30000.
REQ-028 a=2047, b=2047 -> prod=4190209; a=0, b=2047 -> prod=0 with full latency (macro undefined).
REQ-029 start held high for 30 cycles, with a/b changed during RUN -> results use only the operands captured at each accept; accepts are 13 cycles apart.
REQ-030 rst pulsed low during the 5th RUN cycle of 134x132 -> outputs clear asynchronously; the next start 3x5 -> prod=15.
REQ-031 MULT_EARLY_EXIT_EN defined: a=100, b=1 -> done after 2 edges, prod=100; b=1024 -> done after 12 edges, prod=102400.
